// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port
// data memory. The master side is the requester/memory environment, the
// slave side is the arbiter itself.
interface dmem_arbiter_if;
  // requester 0 (core load/store stage)
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;
  // requester 1 (program loader / debug port)
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;
  // single-port memory (synchronous write, combinational read)
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_A, mem_WE, mem_WD,
    output mem_RD
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output mem_A, mem_WE, mem_WD,
    input  mem_RD
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Each access takes three cycles: IDLE (grant and latch), ACCESS (memory
// cycle, write commits / read captured at its closing edge) and RESP (one-cycle
// ack to the winner). Misaligned addresses are flagged and never reach memory.
module dmem_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        win_q, win_d;          // 0 = requester 0 owns the access
  logic        last_grant_q, last_grant_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        grant1_s;
  logic [31:0] access_rdata_s;

  // Pick the winner among the requests currently presented.
  always_comb begin
    grant1_s = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      if (FIXED_PRIORITY) begin
        grant1_s = 1'b0;
      end else begin
        // whoever was not granted last wins; last_grant resets to 1
        grant1_s = ~last_grant_q;
      end
    end else if (bus.m1_req) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
  end

  // Data returned to the winner: memory word for aligned reads, else zero.
  always_comb begin
    access_rdata_s = ZERO_WORD;
    if (we_q || err_q) begin
      access_rdata_s = ZERO_WORD;
    end else begin
      access_rdata_s = bus.mem_RD;
    end
  end

  // Next-state and next-register computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    mem_a_d      = mem_a_q;
    mem_wd_d     = mem_wd_q;
    we_d         = we_q;
    err_d        = err_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          win_d        = grant1_s;
          last_grant_d = grant1_s;
          if (grant1_s) begin
            mem_a_d  = bus.m1_addr;
            mem_wd_d = bus.m1_wdata;
            we_d     = bus.m1_we;
            err_d    = is_misaligned(bus.m1_addr[1:0]);
          end else begin
            mem_a_d  = bus.m0_addr;
            mem_wd_d = bus.m0_wdata;
            we_d     = bus.m0_we;
            err_d    = is_misaligned(bus.m0_addr[1:0]);
          end
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // write commits and read data is captured at the edge leaving ACCESS
        if (win_q) begin
          rdata1_d = access_rdata_s;
          ack1_d   = 1'b1;
          err1_d   = err_q;
        end else begin
          rdata0_d = access_rdata_s;
          ack0_d   = 1'b1;
          err0_d   = err_q;
        end
        state_d = RESP;
      end

      RESP: begin
        // requests are not looked at here; the next grant happens in IDLE
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_a_q      <= ZERO_WORD;
      mem_wd_q     <= ZERO_WORD;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= ZERO_WORD;
      rdata1_q     <= ZERO_WORD;
    end else begin
      state_q      <= state_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
      we_q         <= we_d;
      err_q        <= err_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Write strobe: only in ACCESS, never for misaligned accesses, and killed
  // immediately by reset so an interrupted write cannot commit.
  always_comb begin
    bus.mem_WE = (state_q == ACCESS) & we_q & ~err_q & ~reset;
  end

  assign bus.mem_A    = mem_a_q;
  assign bus.mem_WD   = mem_wd_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_err   = err0_q;
  assign bus.m1_err   = err1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one round-robin instance and one
// fixed-priority instance, each with its own behavioural memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.FIXED_PRIORITY(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_arbiter #(.FIXED_PRIORITY(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // behavioural memories with a bench preload port
  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];
  logic        pre_we0 = 1'b0, pre_we1 = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;

  assign bus0.mem_RD = mem0[bus0.mem_A[7:2]];
  assign bus1.mem_RD = mem1[bus1.mem_A[7:2]];

  // memory 0 write port
  always @(posedge clk) begin
    if (pre_we0) mem0[pre_idx] <= pre_val;
    else if (bus0.mem_WE) mem0[bus0.mem_A[7:2]] <= bus0.mem_WD;
  end

  // memory 1 write port
  always @(posedge clk) begin
    if (pre_we1) mem1[pre_idx] <= pre_val;
    else if (bus1.mem_WE) mem1[bus1.mem_A[7:2]] <= bus1.mem_WD;
  end

  task automatic preload(input int which, input logic [5:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    if (which == 0) pre_we0 = 1'b1; else pre_we1 = 1'b1;
    @(negedge clk);
    pre_we0 = 1'b0;
    pre_we1 = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.m0_ack, bus0.m1_ack, bus0.m0_err, bus0.m1_err, bus0.mem_WE,
           bus0.m0_rdata, bus0.m1_rdata, bus0.mem_A, bus0.mem_WD} !== 133'd0)
        $display("FAIL reset_outputs0: got ack=%b%b err=%b%b we=%b rd0=%h rd1=%h A=%h WD=%h, expected all 0",
                 bus0.m0_ack, bus0.m1_ack, bus0.m0_err, bus0.m1_err, bus0.mem_WE,
                 bus0.m0_rdata, bus0.m1_rdata, bus0.mem_A, bus0.mem_WD);
      else passes++;
      checks++;
      if ({bus1.m0_ack, bus1.m1_ack, bus1.mem_WE, bus1.mem_A} !== 35'd0)
        $display("FAIL reset_outputs1: got ack=%b%b we=%b A=%h, expected all 0",
                 bus1.m0_ack, bus1.m1_ack, bus1.mem_WE, bus1.mem_A);
      else passes++;
      checks++;
      if (dut0.state_q != 2'd0) $display("FAIL reset_state: got %0d expected 0", dut0.state_q);
      else passes++;
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b1;
    bus0.m0_addr = 32'h10; bus0.m0_wdata = 32'hDEADBEEF;
    @(negedge clk); // ACCESS
    checks++;
    if ({bus0.mem_WE, bus0.mem_A, bus0.mem_WD, bus0.m0_ack} !== {1'b1, 32'h10, 32'hDEADBEEF, 1'b0})
      $display("FAIL wr_access: got we=%b A=%h WD=%h ack=%b, expected we=1 A=10 WD=deadbeef ack=0",
               bus0.mem_WE, bus0.mem_A, bus0.mem_WD, bus0.m0_ack);
    else passes++;
    @(negedge clk); // RESP
    checks++;
    if ({bus0.m0_ack, bus0.m0_err, bus0.mem_WE, bus0.m1_ack} !== 4'b1000)
      $display("FAIL wr_resp: got ack=%b err=%b we=%b m1ack=%b, expected 1 0 0 0",
               bus0.m0_ack, bus0.m0_err, bus0.mem_WE, bus0.m1_ack);
    else passes++;
    checks++;
    if (mem0[4] !== 32'hDEADBEEF) $display("FAIL wr_mem: got %h expected deadbeef", mem0[4]);
    else passes++;
    bus0.m0_req = 1'b0;
    @(negedge clk); // IDLE
    checks++;
    if (bus0.m0_ack !== 1'b0) $display("FAIL wr_ack_pulse: got %b expected 0", bus0.m0_ack);
    else passes++;
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.mem_WE !== 1'b0) $display("FAIL rd_no_we: got %b expected 0", bus0.mem_WE);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus0.m0_ack, bus0.m0_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL rd_data: got ack=%b data=%h expected ack=1 data=deadbeef", bus0.m0_ack, bus0.m0_rdata);
    else passes++;
    bus0.m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last_i = 0;
    logic exp_port;
    logic [31:0] got, exp_data;
    preload(0, 6'd1, 32'h1111_1111);
    preload(0, 6'd2, 32'h2222_2222);
    reset_pulse();
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b0; bus0.m0_addr = 32'h04;
    bus0.m1_req = 1'b1; bus0.m1_we = 1'b0; bus0.m1_addr = 32'h08;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus0.m0_ack && bus0.m1_ack) begin
        checks++;
        $display("FAIL rr_double_ack: got both acks at cycle %0d, expected one", i);
      end
      if (bus0.m0_ack || bus0.m1_ack) begin
        exp_port = n[0];
        exp_data = exp_port ? 32'h2222_2222 : 32'h1111_1111;
        got = bus0.m1_ack ? bus0.m1_rdata : bus0.m0_rdata;
        checks++;
        if (bus0.m1_ack !== exp_port) $display("FAIL rr_order: ack %0d from port %b expected %b", n, bus0.m1_ack, exp_port);
        else passes++;
        checks++;
        if (got !== exp_data) $display("FAIL rr_data: ack %0d data %h expected %h", n, got, exp_data);
        else passes++;
        checks++;
        if (i - last_i != ((n == 0) ? 2 : 3)) $display("FAIL rr_spacing: ack %0d gap %0d expected %0d", n, i - last_i, (n == 0) ? 2 : 3);
        else passes++;
        last_i = i;
        n++;
        if (n == 4) begin
          bus0.m0_req = 1'b0;
          bus0.m1_req = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (n != 4) begin
      $display("FAIL rr_count: got %0d acks expected 4", n);
      bus0.m0_req = 1'b0;
      bus0.m1_req = 1'b0;
    end else passes++;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int n0 = 0;
    int n1 = 0;
    preload(1, 6'd1, 32'hAAAA_0001);
    preload(1, 6'd2, 32'hBBBB_0002);
    reset_pulse();
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 32'h04;
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 32'h08;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (bus1.m0_ack) begin
        n0++;
        checks++;
        if (bus1.m0_rdata !== 32'hAAAA_0001) $display("FAIL fp_m0_data: got %h expected aaaa0001", bus1.m0_rdata);
        else passes++;
      end
      if (bus1.m1_ack && i <= 10) n1++;
      if (i == 8) bus1.m0_req = 1'b0;
      if (i == 10) begin
        checks++;
        if ({bus1.mem_A, dut1.state_q} !== {32'h08, 2'd1})
          $display("FAIL fp_m1_grant: got A=%h state=%0d expected A=8 state=1", bus1.mem_A, dut1.state_q);
        else passes++;
      end
      if (i == 11) begin
        checks++;
        if ({bus1.m1_ack, bus1.m0_ack, bus1.m1_rdata} !== {1'b1, 1'b0, 32'hBBBB_0002})
          $display("FAIL fp_m1_ack: got ack1=%b ack0=%b data=%h expected 1 0 bbbb0002",
                   bus1.m1_ack, bus1.m0_ack, bus1.m1_rdata);
        else passes++;
        bus1.m1_req = 1'b0;
      end
    end
    checks++;
    if (n0 != 3) $display("FAIL fp_m0_count: got %0d expected 3", n0);
    else passes++;
    checks++;
    if (n1 != 0) $display("FAIL fp_m1_starved: got %0d expected 0", n1);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    bus0.m1_req = 1'b1; bus0.m1_we = 1'b1;
    bus0.m1_addr = 32'h06; bus0.m1_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({bus0.mem_WE, bus0.mem_A} !== {1'b0, 32'h06})
      $display("FAIL mis_access: got we=%b A=%h expected we=0 A=6", bus0.mem_WE, bus0.mem_A);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus0.m1_ack, bus0.m1_err, bus0.m1_rdata, bus0.mem_WE, bus0.m0_ack} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL mis_resp: got ack=%b err=%b data=%h we=%b ack0=%b expected 1 1 0 0 0",
               bus0.m1_ack, bus0.m1_err, bus0.m1_rdata, bus0.mem_WE, bus0.m0_ack);
    else passes++;
    checks++;
    if (mem0[1] !== 32'h1111_1111) $display("FAIL mis_mem: got %h expected 11111111", mem0[1]);
    else passes++;
    bus0.m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b1;
    bus0.m0_addr = 32'h30; bus0.m0_wdata = 32'h01020304;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2 || i == 5) begin
        checks++;
        if (bus0.m0_ack !== 1'b1) $display("FAIL b2b_ack: cycle %0d got %b expected 1", i, bus0.m0_ack);
        else passes++;
      end else begin
        checks++;
        if (bus0.m0_ack !== 1'b0) $display("FAIL b2b_noack: cycle %0d got %b expected 0", i, bus0.m0_ack);
        else passes++;
      end
      if (i == 2) begin
        bus0.m0_addr = 32'h34; bus0.m0_wdata = 32'h05060708;
      end
      if (i == 4) begin
        checks++;
        if ({bus0.mem_WE, bus0.mem_A} !== {1'b1, 32'h34})
          $display("FAIL b2b_second: got we=%b A=%h expected we=1 A=34", bus0.mem_WE, bus0.mem_A);
        else passes++;
      end
    end
    bus0.m0_req = 1'b0;
    checks++;
    if ({mem0[12], mem0[13]} !== {32'h01020304, 32'h05060708})
      $display("FAIL b2b_mem: got %h %h expected 01020304 05060708", mem0[12], mem0[13]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    bus0.m1_req = 1'b1; bus0.m1_we = 1'b0; bus0.m1_addr = 32'h10;
    @(negedge clk);
    bus0.m1_req = 1'b0; // dropped before ack
    @(negedge clk);
    checks++;
    if ({bus0.m1_ack, bus0.m1_err, bus0.m1_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL drop_ack: got ack=%b err=%b data=%h expected 1 0 deadbeef",
               bus0.m1_ack, bus0.m1_err, bus0.m1_rdata);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    preload(0, 6'd8, 32'hA5A5_A5A5);
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b1;
    bus0.m0_addr = 32'h20; bus0.m0_wdata = 32'hCAFEF00D;
    @(negedge clk); // ACCESS
    checks++;
    if (bus0.mem_WE !== 1'b1) $display("FAIL rst_pre_we: got %b expected 1", bus0.mem_WE);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (bus0.mem_WE !== 1'b0) $display("FAIL rst_we_kill: got %b expected 0", bus0.mem_WE);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus0.m0_ack, dut0.state_q} !== {1'b0, 2'd0})
      $display("FAIL rst_abort: got ack=%b state=%0d expected 0 0", bus0.m0_ack, dut0.state_q);
    else passes++;
    checks++;
    if (mem0[8] !== 32'hA5A5_A5A5) $display("FAIL rst_no_write: got %h expected a5a5a5a5", mem0[8]);
    else passes++;
    reset = 1'b0;
    bus0.m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.m0_ack !== 1'b0) $display("FAIL rst_no_ack: got %b expected 0", bus0.m0_ack);
    else passes++;
    bus0.m0_req = 1'b1; bus0.m0_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus0.m0_ack, bus0.m0_rdata} !== {1'b1, 32'hA5A5_A5A5})
      $display("FAIL rst_readback: got ack=%b data=%h expected 1 a5a5a5a5", bus0.m0_ack, bus0.m0_rdata);
    else passes++;
    bus0.m0_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus0.m0_req = 1'b0; bus0.m0_we = 1'b0; bus0.m0_addr = 32'h0; bus0.m0_wdata = 32'h0;
    bus0.m1_req = 1'b0; bus0.m1_we = 1'b0; bus0.m1_addr = 32'h0; bus0.m1_wdata = 32'h0;
    bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = 32'h0; bus1.m0_wdata = 32'h0;
    bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = 32'h0; bus1.m1_wdata = 32'h0;
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_misaligned();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
